// File: rtl/acc_bank_if.sv
// Sample/read bus for the acc_bank multi-channel accumulator.
// Channel index width is derived from NCH (minimum 1 bit).
interface acc_bank_if #(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 16,
    parameter int unsigned NCH = 4
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;

    logic          in_valid;
    logic [CW-1:0] in_ch;
    logic [DW-1:0] in_d;
    logic          clr_all;
    logic          rd_req;
    logic [CW-1:0] rd_ch;
    logic          rd_clr;
    logic          rd_valid;
    logic [AW-1:0] rd_data;
    logic          ovf;

    modport master (
        output in_valid, in_ch, in_d, clr_all, rd_req, rd_ch, rd_clr,
        input  rd_valid, rd_data, ovf
    );

    modport slave (
        input  in_valid, in_ch, in_d, clr_all, rd_req, rd_ch, rd_clr,
        output rd_valid, rd_data, ovf
    );
endinterface

// File: rtl/acc_bank.sv
// NCH-channel signed accumulator bank with wrap/saturate, clear-on-read and global clear.
// Optional per-channel sticky overflow flags: define ACC_BANK_OVF_STICKY_EN.
module acc_bank #(
    parameter int unsigned DW  = 8,
    parameter int unsigned AW  = 16,
    parameter int unsigned NCH = 4,
    parameter int unsigned SAT = 0
) (
    input  logic           clk,
    input  logic           rst_n,
    acc_bank_if.slave      bus
`ifdef ACC_BANK_OVF_STICKY_EN
    ,
    output logic [NCH-1:0] ovf_sticky
`endif
);
    localparam int unsigned CW = (NCH > 1) ? $clog2(NCH) : 1;
    localparam logic [AW-1:0] ACC_MAX = {1'b0, {(AW-1){1'b1}}};
    localparam logic [AW-1:0] ACC_MIN = {1'b1, {(AW-1){1'b0}}};

    logic [AW-1:0] acc_q [NCH];
    logic [AW-1:0] acc_d [NCH];
    logic [AW-1:0] cur_acc;
    logic [AW-1:0] rd_sel;
    logic [AW-1:0] base;
    logic [AW-1:0] res;
    logic [AW:0]   sum;
    logic          samp_ok;
    logic          rdclr_hit;
    logic          ovf_raw;
    logic          ovf_d;

    // Channel select; out-of-range indices match nothing, so samples drop and reads return 0.
    always_comb begin
        cur_acc = '0;
        rd_sel  = '0;
        samp_ok = 1'b0;
        for (int c = 0; c < NCH; c++) begin
            if (bus.in_ch == CW'(c)) begin
                cur_acc = acc_q[c];
                samp_ok = bus.in_valid;
            end
            if (bus.rd_ch == CW'(c)) begin
                rd_sel = acc_q[c];
            end
        end
    end

    // Clear-on-read colliding with a sample restarts the channel from the sample itself.
    always_comb begin
        rdclr_hit = bus.rd_req & bus.rd_clr & (bus.rd_ch == bus.in_ch);
        base      = rdclr_hit ? '0 : cur_acc;
        sum       = {base[AW-1], base} + {{(AW+1-DW){bus.in_d[DW-1]}}, bus.in_d};
        ovf_raw   = sum[AW] ^ sum[AW-1];
        res       = sum[AW-1:0];
        if ((SAT != 0) && ovf_raw) begin
            res = sum[AW] ? ACC_MIN : ACC_MAX;
        end
        ovf_d = samp_ok & ovf_raw & ~bus.clr_all;
    end

    // Per-channel priority: clr_all > sample (incl. collision) > clear-on-read > hold.
    always_comb begin
        for (int c = 0; c < NCH; c++) begin
            acc_d[c] = acc_q[c];
            if (bus.clr_all) begin
                acc_d[c] = '0;
            end else if (samp_ok && (bus.in_ch == CW'(c))) begin
                acc_d[c] = res;
            end else if (bus.rd_req && bus.rd_clr && (bus.rd_ch == CW'(c))) begin
                acc_d[c] = '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= '0;
            end
            bus.rd_valid <= 1'b0;
            bus.rd_data  <= '0;
            bus.ovf      <= 1'b0;
        end else begin
            for (int c = 0; c < NCH; c++) begin
                acc_q[c] <= acc_d[c];
            end
            bus.rd_valid <= bus.rd_req;
            if (bus.rd_req) begin
                bus.rd_data <= rd_sel;
            end
            bus.ovf <= ovf_d;
        end
    end

`ifdef ACC_BANK_OVF_STICKY_EN
    logic [NCH-1:0] sticky_d;

    // clr_all beats a same-cycle set; a set beats clear-on-read.
    always_comb begin
        sticky_d = ovf_sticky;
        for (int c = 0; c < NCH; c++) begin
            if (bus.clr_all) begin
                sticky_d[c] = 1'b0;
            end else if (ovf_d && (bus.in_ch == CW'(c))) begin
                sticky_d[c] = 1'b1;
            end else if (bus.rd_req && bus.rd_clr && (bus.rd_ch == CW'(c))) begin
                sticky_d[c] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_sticky <= '0;
        end else begin
            ovf_sticky <= sticky_d;
        end
    end
`endif
endmodule

// File: tb/tb_acc_bank.sv
// Directed bench for acc_bank: default, 8-bit wrap (NCH=3) and 8-bit saturate instances.
module tb_acc_bank;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    acc_bank_if #(.DW(8), .AW(16), .NCH(4)) b0 ();
    acc_bank_if #(.DW(8), .AW(8),  .NCH(3)) b1 ();
    acc_bank_if #(.DW(8), .AW(8),  .NCH(4)) b2 ();

`ifdef ACC_BANK_OVF_STICKY_EN
    logic [3:0] st0;
    logic [2:0] st1;
    logic [3:0] st2;
`endif

    acc_bank #(.DW(8), .AW(16), .NCH(4), .SAT(0)) u0 (
        .clk(clk), .rst_n(rst_n), .bus(b0)
`ifdef ACC_BANK_OVF_STICKY_EN
        , .ovf_sticky(st0)
`endif
    );
    acc_bank #(.DW(8), .AW(8), .NCH(3), .SAT(0)) u1 (
        .clk(clk), .rst_n(rst_n), .bus(b1)
`ifdef ACC_BANK_OVF_STICKY_EN
        , .ovf_sticky(st1)
`endif
    );
    acc_bank #(.DW(8), .AW(8), .NCH(4), .SAT(1)) u2 (
        .clk(clk), .rst_n(rst_n), .bus(b2)
`ifdef ACC_BANK_OVF_STICKY_EN
        , .ovf_sticky(st2)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_all();
        b0.in_valid = 0; b0.in_ch = 0; b0.in_d = 0; b0.clr_all = 0; b0.rd_req = 0; b0.rd_ch = 0; b0.rd_clr = 0;
        b1.in_valid = 0; b1.in_ch = 0; b1.in_d = 0; b1.clr_all = 0; b1.rd_req = 0; b1.rd_ch = 0; b1.rd_clr = 0;
        b2.in_valid = 0; b2.in_ch = 0; b2.in_d = 0; b2.clr_all = 0; b2.rd_req = 0; b2.rd_ch = 0; b2.rd_clr = 0;
    endtask

    task automatic read0(input logic [1:0] ch, input logic clr, input logic [15:0] exp, input string tag);
        b0.rd_req = 1; b0.rd_ch = ch; b0.rd_clr = clr;
        tick();
        b0.rd_req = 0; b0.rd_clr = 0;
        chk({tag, "_valid"}, 32'(b0.rd_valid), 32'd1);
        chk(tag, 32'(b0.rd_data), 32'(exp));
    endtask

    task automatic read1(input logic [1:0] ch, input logic [7:0] exp, input string tag);
        b1.rd_req = 1; b1.rd_ch = ch; b1.rd_clr = 0;
        tick();
        b1.rd_req = 0;
        chk({tag, "_valid"}, 32'(b1.rd_valid), 32'd1);
        chk(tag, 32'(b1.rd_data), 32'(exp));
    endtask

    task automatic read2(input logic [1:0] ch, input logic clr, input logic [7:0] exp, input string tag);
        b2.rd_req = 1; b2.rd_ch = ch; b2.rd_clr = clr;
        tick();
        b2.rd_req = 0; b2.rd_clr = 0;
        chk({tag, "_valid"}, 32'(b2.rd_valid), 32'd1);
        chk(tag, 32'(b2.rd_data), 32'(exp));
    endtask

    initial begin
        rst_n = 1'b1;
        idle_all();
        #2 rst_n = 1'b0;
        #1;
        chk("rst_rd_valid", 32'(b0.rd_valid), 32'd0);
        chk("rst_rd_data",  32'(b0.rd_data),  32'd0);
        chk("rst_ovf",      32'(b0.ovf),      32'd0);
        chk("rst_ovf_sat",  32'(b2.ovf),      32'd0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_rd_valid", 32'(b0.rd_valid), 32'd0);

        // Accumulate +5, +7, -3 into ch2
        b0.in_valid = 1; b0.in_ch = 2; b0.in_d = 8'd5;
        tick();
        b0.in_d = 8'd7;
        tick();
        b0.in_d = 8'hFD;
        tick();
        b0.in_valid = 0;
        read0(2, 0, 16'd9, "acc_ch2");
        tick();
        chk("rd_valid_drop", 32'(b0.rd_valid), 32'd0);
        chk("rd_data_hold",  32'(b0.rd_data),  32'd9);
        read0(0, 0, 16'd0, "acc_ch0");
        read0(1, 0, 16'd0, "acc_ch1");
        read0(3, 0, 16'd0, "acc_ch3");

        // Clear-on-read colliding with a sample to the same channel
        b0.in_valid = 1; b0.in_ch = 3; b0.in_d = 8'd50;
        tick();
        b0.in_d = 8'd4; b0.rd_req = 1; b0.rd_ch = 3; b0.rd_clr = 1;
        tick();
        b0.in_valid = 0; b0.rd_req = 0; b0.rd_clr = 0;
        chk("cor_coll_valid", 32'(b0.rd_valid), 32'd1);
        chk("cor_coll_data",  32'(b0.rd_data),  32'd50);
        read0(3, 0, 16'd4, "cor_coll_after");
        read0(2, 1, 16'd9, "cor_plain");
        read0(2, 0, 16'd0, "cor_plain_after");

        // clr_all with same-cycle sample and read
        b0.in_valid = 1; b0.in_ch = 1; b0.in_d = 8'd33;
        tick();
        b0.in_ch = 0; b0.in_d = 8'd9; b0.clr_all = 1; b0.rd_req = 1; b0.rd_ch = 1;
        tick();
        b0.in_valid = 0; b0.clr_all = 0; b0.rd_req = 0;
        chk("clr_all_rd_valid", 32'(b0.rd_valid), 32'd1);
        chk("clr_all_rd_data",  32'(b0.rd_data),  32'd33);
        chk("clr_all_ovf",      32'(b0.ovf),      32'd0);
        read0(0, 0, 16'd0, "clr_all_ch0");
        read0(1, 0, 16'd0, "clr_all_ch1");
        read0(3, 0, 16'd0, "clr_all_ch3");

        // Wrap: 120 + 10 -> 0x82 with one ovf pulse
        b1.in_valid = 1; b1.in_ch = 0; b1.in_d = 8'd120;
        tick();
        chk("wrap_pre_ovf", 32'(b1.ovf), 32'd0);
        b1.in_d = 8'd10;
        tick();
        b1.in_valid = 0;
        chk("wrap_ovf", 32'(b1.ovf), 32'd1);
        tick();
        chk("wrap_ovf_once", 32'(b1.ovf), 32'd0);
        read1(0, 8'h82, "wrap_ch0");
`ifdef ACC_BANK_OVF_STICKY_EN
        chk("wrap_sticky", 32'(st1), 32'd1);
`endif

        // Out-of-range channel on the NCH=3 instance
        b1.in_valid = 1; b1.in_ch = 3; b1.in_d = 8'h7F;
        tick();
        b1.in_valid = 0;
        chk("oor_ovf", 32'(b1.ovf), 32'd0);
        read1(0, 8'h82, "oor_ch0");
        read1(3, 8'h00, "oor_rd_ch3");
        read1(1, 8'h00, "oor_ch1");
        read1(2, 8'h00, "oor_ch2");

        // clr_all suppresses ovf of an overflowing same-cycle sample
        b1.in_valid = 1; b1.in_ch = 0; b1.in_d = 8'hF6; b1.clr_all = 1;
        read1(0, 8'h82, "clr_ovf_rd");
        b1.in_valid = 0; b1.clr_all = 0;
        chk("clr_all_ovf_sup", 32'(b1.ovf), 32'd0);
        read1(0, 8'h00, "clr_all_wrap_ch0");
`ifdef ACC_BANK_OVF_STICKY_EN
        chk("clr_all_sticky", 32'(st1), 32'd0);
`endif

        // Saturate negative: -120 + -20 -> -128
        b2.in_valid = 1; b2.in_ch = 1; b2.in_d = 8'h88;
        tick();
        b2.in_d = 8'hEC;
        tick();
        b2.in_valid = 0;
        chk("sat_neg_ovf", 32'(b2.ovf), 32'd1);
        read2(1, 0, 8'h80, "sat_neg_ch1");
        chk("sat_ovf_clear", 32'(b2.ovf), 32'd0);

        // Saturate positive: 127 + 1 -> 127
        b2.in_valid = 1; b2.in_ch = 0; b2.in_d = 8'h7F;
        tick();
        b2.in_d = 8'h01;
        tick();
        b2.in_valid = 0;
        chk("sat_pos_ovf", 32'(b2.ovf), 32'd1);
        read2(0, 0, 8'h7F, "sat_pos_ch0");
`ifdef ACC_BANK_OVF_STICKY_EN
        chk("sat_sticky", 32'(st2), 32'd3);
        read2(0, 1, 8'h7F, "sat_cor_ch0");
        chk("sat_sticky_cor", 32'(st2), 32'd2);
`endif

        // Further -1 on a saturated channel clips again
        b2.in_valid = 1; b2.in_ch = 1; b2.in_d = 8'hFF;
        tick();
        b2.in_valid = 0;
        chk("sat_again_ovf", 32'(b2.ovf), 32'd1);
        read2(1, 0, 8'h80, "sat_again_ch1");

        // Async reset with a read pending and ovf high
        b0.in_valid = 1; b0.in_ch = 0; b0.in_d = 8'd100;
        tick();
        b0.in_valid = 0;
        b0.rd_req = 1; b0.rd_ch = 0;
        b2.in_valid = 1; b2.in_ch = 1; b2.in_d = 8'hFF;
        tick();
        chk("pre_rst_rd_valid", 32'(b0.rd_valid), 32'd1);
        chk("pre_rst_rd_data",  32'(b0.rd_data),  32'd100);
        chk("pre_rst_ovf",      32'(b2.ovf),      32'd1);
        idle_all();
        rst_n = 1'b0;
        #1;
        chk("arst_rd_valid", 32'(b0.rd_valid), 32'd0);
        chk("arst_rd_data",  32'(b0.rd_data),  32'd0);
        chk("arst_ovf",      32'(b2.ovf),      32'd0);
`ifdef ACC_BANK_OVF_STICKY_EN
        chk("arst_sticky", 32'(st2), 32'd0);
`endif
        tick();
        rst_n = 1'b1;
        tick();
        read0(0, 0, 16'd0, "post_rst_ch0");
        read2(1, 0, 8'h00, "post_rst_sat_ch1");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/acc_bank.md
Name: acc_bank

Overview:
- Multi-channel signed accumulator bank, and the parametrised successor of the single-channel enable/accumulate block.
- Holds NCH independent accumulators of width AW, each fed from a shared DW-bit sample stream tagged with a channel index.
- Supports wrap or saturate arithmetic, read-out with optional clear-on-read, and a global clear.
- Sits between sample producers (filters, counters) and a register/readout interface.

Parameters:
- DW, 8, input sample width, signed two's complement.
- AW, 16, accumulator width, signed; must be >= DW.
- NCH, 4, number of channels; >= 1.
- CW, $clog2(NCH) (min 1), channel index width; derived, not overridden.
- SAT, 0, 0 = wrap-around arithmetic, 1 = saturate at signed AW limits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  sample valid
- in_ch  in  CW  target channel of sample
- in_d  in  DW  signed sample
- clr_all  in  1  synchronous clear of all channels
- rd_req  in  1  read request
- rd_ch  in  CW  channel to read
- rd_clr  in  1  clear-on-read qualifier, sampled with rd_req
- rd_valid  out  1  read data valid, one-cycle pulse
- rd_data  out  AW  read value
- ovf  out  1  pulse: accepted sample overflowed (wrap) or clipped (sat)

Behaviour:
- Reset (async, rst_n low): all accumulators = 0, rd_valid = 0, rd_data = 0, ovf = 0. Release is used synchronously.
- Sample path (no backpressure; a sample is accepted every cycle in_valid = 1):
  - Sample is sign-extended to AW+1 bits and added to the sign-extended acc[in_ch]; result written at the next clk edge.
  - Single-cycle update; back-to-back samples to the same channel accumulate correctly with no bubble.
- Overflow detection: signed overflow exists when bit AW of the AW+1-bit sum differs from bit AW-1.
  - SAT = 0: store the low AW bits (wrap).
  - SAT = 1: store +(2^(AW-1))-1 on positive overflow, -(2^(AW-1)) on negative overflow.
  - Either mode: ovf = 1 for the following cycle.
- in_ch >= NCH (only when NCH is not a power of 2): sample dropped, no state change, ovf = 0.
- Read path:
  - rd_req in cycle N gives rd_valid = 1 and rd_data = acc[rd_ch] in cycle N+1.
  - The value returned is the pre-edge value at cycle N; it excludes any sample accepted in cycle N.
  - rd_ch >= NCH: rd_valid = 1, rd_data = 0.
  - rd_valid is low on every cycle without a prior rd_req; rd_data holds its last value.
- Clear-on-read (rd_req & rd_clr): acc[rd_ch] is written at the same edge to either in_d (wrap/sat applied) if in_valid targets the same channel that cycle, or 0 otherwise. No sample is lost.
- clr_all:
  - All channels = 0 at the next edge; it overrides any same-cycle sample and rd_clr.
  - A same-cycle rd_req still returns the pre-clear value.
  - ovf = 0 for that sample.
- Priority per channel per edge: clr_all > (rd_clr & sample) > rd_clr > sample > hold.
- Reset asserted mid-operation clears everything immediately; a rd_valid pending from the previous cycle is lost.

Optional Feature:
- Macro: ACC_BANK_OVF_STICKY_EN.
- Defined:
  - Adds output ovf_sticky [NCH-1:0]. Bit c sets on any overflow/clip of channel c.
  - Bit c clears on clear-on-read of c or on clr_all. A set and a clear in the same cycle resolve to clear only when the clear is clr_all; otherwise the set wins.
  - Reset value 0.
- Undefined: port absent, no sticky state; ovf pulse behaviour is unchanged.

Test Plan:
- Accumulate (DW=8, AW=16, NCH=4): samples +5, +7, -3 to ch2 on consecutive cycles, then rd_req ch2 -> rd_valid next cycle, rd_data = 9; other channels read 0.
- Wrap (SAT=0, AW=8, DW=8): ch0 = 120, add +10 -> acc = -126 (0x82), ovf pulses once.
- Saturate (SAT=1, AW=8): ch1 = -120, add -20 -> acc = -128, ovf = 1; a further -1 -> stays -128, ovf = 1 again.
- Clear-on-read collision: ch3 = 50; same cycle rd_req ch3 with rd_clr and sample +4 to ch3 -> rd_data = 50, next read of ch3 = 4.
- clr_all with same-cycle sample +9 to ch0 and rd_req ch1 (ch1 = 33) -> rd_data = 33; all channels read 0 afterwards, ovf = 0.
- Async reset asserted mid-stream while channels are non-zero -> all outputs 0 immediately; reads after release return 0. With ACC_BANK_OVF_STICKY_EN: a sticky bit set before reset reads 0 after it.
